// File: rtl/fifo_wr_ingress_if.sv
// Upstream valid/ready stream into the FIFO write ingress stage.
//   s_valid : source has a word on s_data
//   s_data  : payload word, DATA_WIDTH bits
//   s_ready : sink can take the word this cycle
// master = word source, slave = fifo_wr_ingress.
interface fifo_wr_ingress_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/fifo_wr_ingress.sv
// Write-side ingress stage feeding an async FIFO write port (wclk domain).
// Buffers the upstream stream in a 2-entry skid buffer and issues winc/wdata.
// Writes are gated on a locally computed occupancy (exact write count minus
// the synchronized read pointer) because the FIFO's registered wfull lags
// the write pointer by one write.
//
// Ports:
//   wclk, wrst_n : write clock, synchronous active-low reset
//   s_if         : upstream stream (s_valid, s_data, s_ready), slave side
//   wq2_rptr     : gray read pointer already synchronized into wclk
//   wfull        : registered full flag from the FIFO write block
//   winc, wdata  : write strobe and data toward the FIFO write port/memory
//   level        : local occupancy estimate, 0..DEPTH
//   afull        : level >= DEPTH - AFULL_MARGIN
//   stall_cnt    : saturating count of cycles a buffered word was blocked
module fifo_wr_ingress #(
    parameter int unsigned ADD_WIDTH    = 3,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned AFULL_MARGIN = 2,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    fifo_wr_ingress_if.slave       s_if,
    input  logic [ADD_WIDTH:0]     wq2_rptr,
    input  logic                   wfull,
    output logic                   winc,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic [ADD_WIDTH:0]     level,
    output logic                   afull,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int unsigned PTR_W = ADD_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADD_WIDTH;
    localparam logic [ADD_WIDTH:0] DEPTH_P   = PTR_W'(DEPTH);
    localparam logic [ADD_WIDTH:0] AFULL_LVL = PTR_W'(DEPTH - AFULL_MARGIN);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    logic                  s_ready_q;
    logic                  buf_valid_q;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic [ADD_WIDTH:0]    wcnt;
    logic [ADD_WIDTH:0]    rbin;
    logic [ADD_WIDTH:0]    occ;
    logic                  can_wr;
    logic                  accept;
    logic                  pop;

    // Gray to binary: bit i is the XOR of all gray bits at and above i.
    always_comb begin
        rbin = '0;
        for (int unsigned i = 0; i < PTR_W; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // Modulo-2**PTR_W difference stays correct across pointer wrap.
    always_comb begin
        occ    = wcnt - rbin;
        can_wr = (occ < DEPTH_P) & ~wfull;
        winc   = buf_valid_q & can_wr;
        pop    = winc;
        accept = s_if.s_valid & s_ready_q;
    end

    assign s_if.s_ready = s_ready_q;
    assign wdata        = head;
    assign level        = occ;
    assign afull        = (occ >= AFULL_LVL);

    // Skid buffer FSM. s_ready and buffer-valid are kept as registered
    // copies of (state != TWO) and (state != EMPTY), updated alongside state.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state       <= EMPTY;
            s_ready_q   <= 1'b1;
            buf_valid_q <= 1'b0;
            head        <= '0;
            tail        <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head        <= s_if.s_data;
                        state       <= ONE;
                        buf_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        tail      <= s_if.s_data;
                        state     <= TWO;
                        s_ready_q <= 1'b0;
                    end else if (!accept && pop) begin
                        state       <= EMPTY;
                        buf_valid_q <= 1'b0;
                    end else if (accept && pop) begin
                        // head is written this cycle; the new word replaces it
                        head <= s_if.s_data;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head      <= tail;
                        state     <= ONE;
                        s_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    s_ready_q   <= 1'b1;
                    buf_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Local write count mirrors the FIFO write block's binary pointer.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wcnt <= '0;
        end else if (winc) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            stall_cnt <= '0;
        end else if (buf_valid_q && !can_wr && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: doc/fifo_wr_ingress.md
Name: fifo_wr_ingress

Overview:
- Write-side ingress stage that sits directly upstream of the async FIFO write-pointer/full block, in the write clock domain.
- Accepts a valid/ready stream into a 2-entry skid buffer and generates winc and wdata toward the FIFO write port and memory.
- The FIFO's registered wfull lags the write pointer by one write. This block therefore keeps an exact local write count and gates writes on its own occupancy, computed from the synchronized gray read pointer, so back-to-back writes never overflow.

Parameters:
- ADD_WIDTH, 3, FIFO address width; DEPTH = 2**ADD_WIDTH; pointers are ADD_WIDTH+1 bits.
- DATA_WIDTH, 8, payload width.
- AFULL_MARGIN, 2, free-slot threshold for afull (1..DEPTH).
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, synchronous, active-low; asserted in the same cycles as the FIFO write-side reset.
- s_valid  in  1  upstream word valid.
- s_data  in  DATA_WIDTH  upstream word.
- s_ready  out  1  block can accept a word this cycle.
- wq2_rptr  in  ADD_WIDTH+1  read pointer (gray), already synchronized into wclk.
- wfull  in  1  registered full flag from the FIFO write block.
- winc  out  1  write strobe to the FIFO write block and memory.
- wdata  out  DATA_WIDTH  data written when winc=1.
- level  out  ADD_WIDTH+1  local occupancy estimate, 0..DEPTH.
- afull  out  1  level >= DEPTH-AFULL_MARGIN.
- stall_cnt  out  STALL_CNT_W  cycles a word waited because the FIFO was full; saturates at all-ones.

Behaviour:
- Reset (wrst_n=0 at a wclk edge):
  - Skid buffer emptied; FSM goes to EMPTY.
  - wcnt=0, stall_cnt=0.
  - Outputs in the following cycle: s_ready=1, winc=0, wdata=0, level=0, afull=0 if DEPTH>AFULL_MARGIN.
  - Reset mid-operation discards buffered words without writing them.
- Local write count:
  - wcnt is ADD_WIDTH+1 bits, reset 0, increments by 1 modulo 2**(ADD_WIDTH+1) on every cycle winc=1.
  - It mirrors the FIFO write block's binary pointer exactly.
- Read pointer decode:
  - rbin = gray-to-binary(wq2_rptr), combinational: rbin[MSB]=g[MSB], rbin[i]=rbin[i+1]^g[i].
- Occupancy:
  - occ = (wcnt - rbin) modulo 2**(ADD_WIDTH+1), range 0..DEPTH.
  - Wrap of both pointers past the MSB is handled by the modulo arithmetic.
  - level = occ, combinational from registers.
- Write gating:
  - can_wr = (occ < DEPTH) & ~wfull.
  - winc = buf_valid & can_wr, combinational from registers and the synchronized input; no path from s_valid.
  - wdata = head entry of the skid buffer.
- Skid buffer FSM, with states EMPTY (0 words), ONE (1 word), TWO (2 words):
  - s_ready = (state != TWO).
  - accept = s_valid & s_ready; pop = winc.
  - EMPTY: accept -> ONE.
  - ONE: accept & ~pop -> TWO; ~accept & pop -> EMPTY; accept & pop -> ONE (new word becomes head); otherwise hold.
  - TWO: pop -> ONE (second entry shifts to head); no accept is possible.
  - Order is strictly FIFO; no word is duplicated or dropped.
- Latency and throughput:
  - A word accepted at edge k can be written with winc=1 in the cycle after edge k at the earliest.
  - Sustained throughput is 1 word/cycle while occ < DEPTH.
- Stall counter:
  - stall_cnt increments on every cycle with buf_valid & ~can_wr.
  - It holds at all-ones on saturation.
- Boundary cases:
  - occ=DEPTH-1 with a write this cycle: the next cycle sees occ=DEPTH, so winc=0 even though wfull is still 0.
  - wfull=1 while occ<DEPTH (late read-pointer view): wfull wins, winc=0.
  - An accept and a pop in the same cycle at state ONE: the state is unchanged and data advances.

Test Plan:
- Reset, then s_valid=1 with data 0x01..0x08 streamed, wq2_rptr held 0 (ADD_WIDTH=3) -> exactly 8 winc pulses on consecutive cycles starting 1 cycle after the first accept; wdata=0x01..0x08 in order; level reaches 8; winc=0 afterwards although wfull lags.
- Continue from the previous scenario with 0x09, 0x0A offered -> state TWO, s_ready=0, stall_cnt increments each cycle. Then wq2_rptr steps gray 0000 -> 0001 -> 0011 -> winc=1 once per freed slot; 0x09 then 0x0A written in order.
- Drive wcnt and rptr past the wrap: 20 words written and 20 read -> level=0, then 8 more writes allowed before gating, confirming mod-16 arithmetic.
- Force wfull=1 with level=3 for 4 cycles while a word is buffered -> winc=0 for those cycles, stall_cnt +4; write resumes the cycle wfull drops.
- Assert wrst_n=0 with 2 words buffered -> next cycle s_ready=1, winc=0, level=0, stall_cnt=0; buffered words are never written.
- AFULL_MARGIN=2: write 5 words with no reads -> afull=0; write a 6th -> afull=1 in the next cycle.
